// File: rtl/muldiv_hilo_unit.sv
// Iterative multiply/divide engine that owns the HI/LO registers.
// Latency WIDTH+1 edges (1 for divide-by-zero); busy stalls the pipeline and starts while busy are dropped.
module muldiv_hilo_unit #(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [3:0]       i_con,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_flush,
  input  logic             i_hi_we,
  input  logic             i_lo_we,
  input  logic [WIDTH-1:0] i_wdata,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_dz,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opd;
  logic               r_div;
  logic               r_neg;
  logic               r_neg_rem;
  logic               r_dz_pend;
  logic               r_done;
  logic               r_dz;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_accept;
  logic               w_is_div;
  logic               w_sa;
  logic               w_sb;
  logic               w_b_zero;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_acc_step;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;

  assign w_accept = (r_state == S_IDLE) && i_start && (i_con[3:2] == 2'b11) && !i_flush;
  assign w_is_div = i_con[0];
  assign w_sa     = i_con[1] & i_a[WIDTH-1];
  assign w_sb     = i_con[1] & i_b[WIDTH-1];
  assign w_b_zero = (i_b == '0);
  // Magnitude of the most negative value is 2^(WIDTH-1), which is exact as unsigned.
  assign w_mag_a  = w_sa ? -i_a : i_a;
  assign w_mag_b  = w_sb ? -i_b : i_b;

  // Multiply: acc = {partial product, remaining multiplier bits}.
  assign w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opd} : '0);

  // Divide: acc = {remainder, dividend bits being shifted out / quotient bits shifted in}.
  assign w_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_opd};
  assign w_ge    = ~w_diff[WIDTH];

  assign w_acc_step = r_div
    ? {(w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge}
    : {w_sum, r_acc[WIDTH-1:1]};

  assign w_prod   = r_neg ? -r_acc : r_acc;
  assign w_res_hi = r_div ? (r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH])
                          : w_prod[2*WIDTH-1:WIDTH];
  assign w_res_lo = r_div ? (r_neg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0])
                          : w_prod[WIDTH-1:0];

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = (w_is_div && w_b_zero) ? S_FIX : S_CALC;
      S_CALC: if (r_cnt == '0) w_state_nxt = S_FIX;
      S_FIX:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (i_flush && r_state != S_IDLE) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_opd     <= '0;
      r_div     <= 1'b0;
      r_neg     <= 1'b0;
      r_neg_rem <= 1'b0;
      r_dz_pend <= 1'b0;
      r_done    <= 1'b0;
      r_dz      <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_hi_we) r_hi <= i_wdata;
          if (i_lo_we) r_lo <= i_wdata;
          if (w_accept) begin
            r_div     <= w_is_div;
            r_neg     <= w_sa ^ w_sb;
            r_neg_rem <= w_sa;
            r_dz_pend <= w_is_div && w_b_zero;
            r_cnt     <= CW'(WIDTH - 1);
            r_acc     <= w_is_div ? {{WIDTH{1'b0}}, w_mag_a} : {{WIDTH{1'b0}}, w_mag_b};
            r_opd     <= w_is_div ? w_mag_b : w_mag_a;
          end
        end
        S_CALC: begin
          r_acc <= w_acc_step;
          r_cnt <= r_cnt - CW'(1);
        end
        S_FIX: begin
          if (!i_flush) begin
            r_done <= 1'b1;
            r_dz   <= r_dz_pend;
            if (!r_dz_pend) begin
              r_hi <= w_res_hi;
              r_lo <= w_res_lo;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy = (r_state != S_IDLE);
  assign o_done = r_done;
  assign o_dz   = r_dz;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule
